cpu_sequencer: RTL and testbench

- Instruction-cycle controller for the core. It replaces the free-running 2-bit state counter with a handshaked FSM: FETCH, DECODE, EXECUTE, WRITE_BACK, HALT.
- It sequences instr_mem, decoder, alu_unit, pc_cntrl and regbank. It generates the pc advance enable, the branch decision and the regbank write enable.
- It adds fetch wait-states, multi-cycle ALU ops, single-step debug, halt/resume, a fetch timeout fault, and cycle and retired-instruction counters.

---
 rtl/cpu_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: FETCH/DECODE/EXECUTE/WRITE_BACK/HALT sequencing with
// fetch wait-states, multi-cycle ALU, single-step debug, fetch timeout fault and counters.
module cpu_sequencer #(
   parameter int CNT_W         = 32,
   parameter int FETCH_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_ready,
   input  logic             halt_inst,
   input  logic             is_branch,
   input  logic             is_negated_branch,
   input  logic             cond_bit,
   input  logic             alu_multicycle,
   input  logic             alu_done,
   input  logic             run,
   input  logic             step,
   input  logic             resume,
   output logic [2:0]       state,
   output logic             fetch_req,
   output logic             ir_load,
   output logic             alu_start,
   output logic             pc_enable,
   output logic             take_branch,
   output logic             reg_we,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH      = 3'd0,
      S_DECODE     = 3'd1,
      S_EXECUTE    = 3'd2,
      S_WRITE_BACK = 3'd3,
      S_HALT       = 3'd4
   } state_e;

   localparam logic [7:0] TIMEOUT = 8'(FETCH_TIMEOUT);

   state_e           state_q, state_d;
   logic             armed_q, armed_d;
   logic             exec_first_q, exec_first_d;
   logic             fault_q, fault_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic fetch_req_c, ir_load_c, alu_start_c, pc_enable_c, take_branch_c, reg_we_c;

   // Handshakes: an instruction transfers in a cycle where fetch_req and mem_ready are
   // both high (ir_load); a multi-cycle op completes in the EXECUTE cycle where alu_done is high.
   always_comb begin
      state_d       = state_q;
      armed_d       = armed_q;
      exec_first_d  = 1'b0;
      fault_d       = fault_q;
      wait_d        = wait_q;
      instret_d     = instret_q;
      cycle_d       = (state_q != S_HALT) ? cycle_q + CNT_W'(1) : cycle_q;
      fetch_req_c   = 1'b0;
      ir_load_c     = 1'b0;
      alu_start_c   = 1'b0;
      pc_enable_c   = 1'b0;
      take_branch_c = 1'b0;
      reg_we_c      = 1'b0;

      case (state_q)
         S_FETCH: begin
            fetch_req_c = run | armed_q;
            if (!run && step) armed_d = 1'b1;
            if (fetch_req_c && mem_ready) begin
               ir_load_c = 1'b1;
               state_d   = S_DECODE;
               armed_d   = 1'b0;
               wait_d    = 8'd0;
            end else if (fetch_req_c) begin
               // Fault on the wait cycle that brings the count up to the timeout.
               if (wait_q == TIMEOUT - 8'd1) begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
                  wait_d  = 8'd0;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
         end
         S_DECODE: begin
            if (halt_inst) begin
               state_d = S_HALT;
            end else begin
               state_d      = S_EXECUTE;
               exec_first_d = 1'b1;
            end
         end
         S_EXECUTE: begin
            alu_start_c = alu_multicycle & exec_first_q;
            if (!alu_multicycle || alu_done) state_d = S_WRITE_BACK;
         end
         S_WRITE_BACK: begin
            pc_enable_c   = 1'b1;
            take_branch_c = is_branch & (cond_bit ^ is_negated_branch);
            reg_we_c      = ~is_branch;
            instret_d     = instret_q + CNT_W'(1);
            state_d       = S_FETCH;
         end
         S_HALT: begin
            if (resume) begin
               pc_enable_c = 1'b1;
               state_d     = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         armed_q      <= 1'b0;
         exec_first_q <= 1'b0;
         fault_q      <= 1'b0;
         wait_q       <= 8'd0;
         cycle_q      <= '0;
         instret_q    <= '0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         exec_first_q <= exec_first_d;
         fault_q      <= fault_d;
         wait_q       <= wait_d;
         cycle_q      <= cycle_d;
         instret_q    <= instret_d;
      end
   end

   // Reset suppresses every pulse so an abandoned instruction never commits.
   assign fetch_req   = fetch_req_c   & ~reset;
   assign ir_load     = ir_load_c     & ~reset;
   assign alu_start   = alu_start_c   & ~reset;
   assign pc_enable   = pc_enable_c   & ~reset;
   assign take_branch = take_branch_c & ~reset;
   assign reg_we      = reg_we_c      & ~reset;

   assign state       = state_q;
   assign halted      = (state_q == S_HALT);
   assign fault       = fault_q;
   assign cycle_count = cycle_q;
   assign instret     = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: the driver pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares state, pulses and counters.
module tb_cpu_sequencer;

   localparam int CNT_W = 32;
   localparam int EW    = 75;

   logic clk = 1'b0;
   logic reset, mem_ready, halt_inst, is_branch, is_negated_branch, cond_bit;
   logic alu_multicycle, alu_done, run, step, resume;
   logic [2:0]       state;
   logic             fetch_req, ir_load, alu_start, pc_enable, take_branch, reg_we, halted, fault;
   logic [CNT_W-1:0] cycle_count, instret;

   logic [EW-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   int e_cyc    = 0;
   int e_ret    = 0;
   int cyc_no   = 0;

   always #5 clk = ~clk;

   cpu_sequencer #(.CNT_W(CNT_W), .FETCH_TIMEOUT(16)) dut (
      .clk               (clk),
      .reset             (reset),
      .mem_ready         (mem_ready),
      .halt_inst         (halt_inst),
      .is_branch         (is_branch),
      .is_negated_branch (is_negated_branch),
      .cond_bit          (cond_bit),
      .alu_multicycle    (alu_multicycle),
      .alu_done          (alu_done),
      .run               (run),
      .step              (step),
      .resume            (resume),
      .state             (state),
      .fetch_req         (fetch_req),
      .ir_load           (ir_load),
      .alu_start         (alu_start),
      .pc_enable         (pc_enable),
      .take_branch       (take_branch),
      .reg_we            (reg_we),
      .halted            (halted),
      .fault             (fault),
      .cycle_count       (cycle_count),
      .instret           (instret)
   );

   // pl = {fetch_req, ir_load, alu_start, pc_enable, take_branch, reg_we, halted, fault}
   task automatic tick(input logic [2:0] st, input logic [7:0] pl);
      exp_q.push_back({st, pl, 32'(e_cyc), 32'(e_ret)});
      if (reset) begin
         e_cyc = 0;
         e_ret = 0;
      end else begin
         if (st != 3'd4) e_cyc++;
         if (st == 3'd3) e_ret++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [7:0] wb_pl);
      tick(3'd0, 8'b1100_0000);
      tick(3'd1, 8'b0000_0000);
      tick(3'd2, 8'b0000_0000);
      tick(3'd3, wb_pl);
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      logic [7:0]    got_p;
      if (exp_q.size() > 0) begin
         e     = exp_q.pop_front();
         got_p = {fetch_req, ir_load, alu_start, pc_enable, take_branch, reg_we, halted, fault};
         checks++;
         if (state !== e[74:72] || got_p !== e[71:64]) begin
            failures++;
            $display("FAIL outputs cycle=%0d got state=%0d pulses=%b exp state=%0d pulses=%b",
                     cyc_no, state, got_p, e[74:72], e[71:64]);
         end
         checks++;
         if (cycle_count !== e[63:32] || instret !== e[31:0]) begin
            failures++;
            $display("FAIL counters cycle=%0d got cycle_count=%0d instret=%0d exp cycle_count=%0d instret=%0d",
                     cyc_no, cycle_count, instret, e[63:32], e[31:0]);
         end
      end
      cyc_no++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; mem_ready = 1'b1; halt_inst = 1'b0; is_branch = 1'b0;
      is_negated_branch = 1'b0; cond_bit = 1'b0; alu_multicycle = 1'b0; alu_done = 1'b0;
      run = 1'b1; step = 1'b0; resume = 1'b0;
      @(posedge clk);
      #1;
      tick(3'd0, 8'b0000_0000);
      reset = 1'b0;

      // free-run, non-branch: 0,1,2,3 repeating, counters reach 12/3
      repeat (3) instr(8'b0001_0100);

      // branch taken (cond=1, neg=0), not taken (cond=1, neg=1), taken (cond=0, neg=1)
      is_branch = 1'b1; cond_bit = 1'b1; is_negated_branch = 1'b0;
      instr(8'b0001_1000);
      is_negated_branch = 1'b1;
      instr(8'b0001_0000);
      cond_bit = 1'b0;
      instr(8'b0001_1000);
      is_branch = 1'b0; is_negated_branch = 1'b0;

      // five fetch wait-states then mem_ready
      mem_ready = 1'b0;
      repeat (5) tick(3'd0, 8'b1000_0000);
      mem_ready = 1'b1;
      instr(8'b0001_0100);

      // multi-cycle op, alu_done in the 4th EXECUTE cycle
      tick(3'd0, 8'b1100_0000);
      tick(3'd1, 8'b0000_0000);
      alu_multicycle = 1'b1;
      tick(3'd2, 8'b0010_0000);
      tick(3'd2, 8'b0000_0000);
      tick(3'd2, 8'b0000_0000);
      alu_done = 1'b1;
      tick(3'd2, 8'b0000_0000);
      alu_done = 1'b0;
      tick(3'd3, 8'b0001_0100);

      // alu_done held high throughout: same-cycle done gives a 1-cycle EXECUTE
      alu_done = 1'b1;
      tick(3'd0, 8'b1100_0000);
      tick(3'd1, 8'b0000_0000);
      tick(3'd2, 8'b0010_0000);
      tick(3'd3, 8'b0001_0100);
      alu_done = 1'b0; alu_multicycle = 1'b0;

      // debug stop, then one step retires exactly one instruction
      run = 1'b0;
      repeat (3) tick(3'd0, 8'b0000_0000);
      step = 1'b1;
      tick(3'd0, 8'b0000_0000);
      step = 1'b0;
      instr(8'b0001_0100);
      repeat (2) tick(3'd0, 8'b0000_0000);

      // stepped halt instruction, resume steps past it without branching
      step = 1'b1;
      tick(3'd0, 8'b0000_0000);
      step = 1'b0; halt_inst = 1'b1;
      tick(3'd0, 8'b1100_0000);
      tick(3'd1, 8'b0000_0000);
      halt_inst = 1'b0;
      repeat (3) tick(3'd4, 8'b0000_0010);
      resume = 1'b1; is_branch = 1'b1; cond_bit = 1'b1;
      tick(3'd4, 8'b0001_0010);
      resume = 1'b0; is_branch = 1'b0; cond_bit = 1'b0;
      tick(3'd0, 8'b0000_0000);
      resume = 1'b1;
      tick(3'd0, 8'b0000_0000);
      resume = 1'b0;

      // reset during EXECUTE and during WRITE_BACK abandons the instruction
      run = 1'b1;
      tick(3'd0, 8'b1100_0000);
      tick(3'd1, 8'b0000_0000);
      alu_multicycle = 1'b1;
      tick(3'd2, 8'b0010_0000);
      reset = 1'b1;
      tick(3'd2, 8'b0000_0000);
      reset = 1'b0; alu_multicycle = 1'b0;
      tick(3'd0, 8'b1100_0000);
      tick(3'd1, 8'b0000_0000);
      tick(3'd2, 8'b0000_0000);
      reset = 1'b1;
      tick(3'd3, 8'b0000_0000);
      reset = 1'b0;

      // fetch timeout after 16 wait cycles, sticky fault survives resume
      mem_ready = 1'b0;
      repeat (16) tick(3'd0, 8'b1000_0000);
      repeat (2) tick(3'd4, 8'b0000_0011);
      resume = 1'b1; mem_ready = 1'b1;
      tick(3'd4, 8'b0001_0011);
      resume = 1'b0;
      tick(3'd0, 8'b1100_0001);
      tick(3'd1, 8'b0000_0001);
      tick(3'd2, 8'b0000_0001);
      tick(3'd3, 8'b0001_0101);
      reset = 1'b1;
      tick(3'd0, 8'b0000_0001);
      reset = 1'b0;
      tick(3'd0, 8'b1100_0000);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
